// File: rtl/decode_stage.sv
// Registered, handshaked instruction decode stage with a return-address stack
// for CAL/RET and a branch-shadow squash counter.
package decode_pkg;
  localparam logic [4:0] OPC_NOP = 5'h00;
  localparam logic [4:0] OPC_CAL = 5'h01;
  localparam logic [4:0] OPC_RET = 5'h02;
  localparam logic [4:0] OPC_JMP = 5'h03;
  localparam logic [4:0] OPC_JEZ = 5'h04;
  localparam logic [4:0] OPC_JNZ = 5'h05;
  localparam logic [4:0] OPC_JLZ = 5'h06;
  localparam logic [4:0] OPC_JGZ = 5'h07;
  localparam logic [4:0] OPC_RST = 5'h08;
  localparam logic [4:0] OPC_ST  = 5'h09;

  typedef enum logic {ST_RUN, ST_SQUASH} dec_state_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int UNDEFINED    = 2,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 17,
  parameter int REG_BIT_CNT  = 3,
  parameter int CNTR_WIDTH   = 8,
  parameter int STACK_DEPTH  = 8,
  parameter int BRANCH_SLOTS = 1,
  localparam int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH,
  localparam int SP_W          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COMBINED_DATA-1:0] data_in,
  input  logic [CNTR_WIDTH-1:0]    pc_in,
  input  logic                     zero_f,
  input  logic                     ls_z_f,
  input  logic                     gr_z_f,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    opcode,
  output logic [REG_BIT_CNT-1:0]   reg_sel,
  output logic                     jmp,
  output logic [CNTR_WIDTH-1:0]    jmp_addr,
  output logic                     load,
  output logic                     store,
  output logic                     rst_f,
  output logic [SP_W-1:0]          sp,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SQ_W  = 3;

  // Registered outputs
  logic                   r_out_valid;
  logic [ADDR_WIDTH-1:0]  r_opcode;
  logic [REG_BIT_CNT-1:0] r_reg_sel;
  logic                   r_jmp;
  logic [CNTR_WIDTH-1:0]  r_jmp_addr;
  logic                   r_load;
  logic                   r_store;
  logic                   r_rst_f;
  logic [SP_W-1:0]        r_sp;
  logic                   r_stk_ovf;
  logic                   r_stk_unf;

  logic [CNTR_WIDTH-1:0]  r_stack [STACK_DEPTH];
  dec_state_t             r_state, w_state_next;
  logic [SQ_W-1:0]        r_cnt, w_cnt_next;

  // Field extraction and handshake
  logic [ADDR_WIDTH-1:0]  w_opc;
  logic [REG_BIT_CNT-1:0] w_reg_sel;
  logic [CNTR_WIDTH-1:0]  w_target;
  logic                   w_accept;
  logic                   w_run_accept;
  logic                   w_unused;

  assign w_opc     = data_in[COMBINED_DATA-1 -: ADDR_WIDTH];
  assign w_reg_sel = data_in[COMBINED_DATA-ADDR_WIDTH-UNDEFINED-1 -: REG_BIT_CNT];
  assign w_target  = data_in[CNTR_WIDTH-1:0];
  assign w_unused  = ^data_in;

  assign in_ready     = !r_out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_run_accept = w_accept && (r_state == ST_RUN);

  // Instruction decode
  logic                  w_jmp, w_load, w_store, w_rst_f;
  logic                  w_push, w_pop, w_ovf_set, w_unf_set, w_clr;
  logic [CNTR_WIDTH-1:0] w_addr;
  logic [IDX_W-1:0]      w_top_idx, w_push_idx;

  assign w_top_idx  = IDX_W'(r_sp - 1'b1);
  assign w_push_idx = IDX_W'(r_sp);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_jmp     = 1'b0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_rst_f   = 1'b1;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    w_clr     = 1'b0;
    w_addr    = w_target;
    case (w_opc)
      ADDR_WIDTH'(OPC_CAL): begin
        w_jmp = 1'b1;
        if (r_sp == SP_W'(STACK_DEPTH)) w_ovf_set = 1'b1;
        else                            w_push    = 1'b1;
      end
      ADDR_WIDTH'(OPC_RET): begin
        // An empty stack turns RET into a no-op that only flags the underflow
        if (r_sp == '0) begin
          w_unf_set = 1'b1;
        end else begin
          w_jmp  = 1'b1;
          w_pop  = 1'b1;
          w_addr = r_stack[w_top_idx];
        end
      end
      ADDR_WIDTH'(OPC_JMP): w_jmp = 1'b1;
      ADDR_WIDTH'(OPC_JEZ): w_jmp = zero_f;
      ADDR_WIDTH'(OPC_JNZ): w_jmp = !zero_f;
      ADDR_WIDTH'(OPC_JLZ): w_jmp = ls_z_f;
      ADDR_WIDTH'(OPC_JGZ): w_jmp = gr_z_f;
      ADDR_WIDTH'(OPC_RST): begin
        w_rst_f = 1'b0;
        w_clr   = 1'b1;
      end
      ADDR_WIDTH'(OPC_NOP): ;
      ADDR_WIDTH'(OPC_ST):  w_store = 1'b1;
      default:              w_load  = 1'b1;
    endcase
  end

  // Branch-shadow squash FSM
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_accept) begin
      if (r_state == ST_SQUASH) begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= SQ_W'(1)) w_state_next = ST_RUN;
      end else if (w_jmp && (BRANCH_SLOTS > 0)) begin
        w_state_next = ST_SQUASH;
        w_cnt_next   = SQ_W'(BRANCH_SLOTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments.
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Output register: squashed or drained beats clear the strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_reg_sel   <= '0;
      r_jmp       <= 1'b0;
      r_jmp_addr  <= '0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_rst_f     <= 1'b1;
    end else if (w_run_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_opc;
      r_reg_sel   <= w_reg_sel;
      r_jmp       <= w_jmp;
      r_jmp_addr  <= w_addr;
      r_load      <= w_load;
      r_store     <= w_store;
      r_rst_f     <= w_rst_f;
    end else if (w_accept || out_ready) begin
      r_out_valid <= 1'b0;
      r_jmp       <= 1'b0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_rst_f     <= 1'b1;
    end
  end

  // Stack pointer and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp      <= '0;
      r_stk_ovf <= 1'b0;
      r_stk_unf <= 1'b0;
    end else if (w_run_accept) begin
      if (w_clr) begin
        r_sp      <= '0;
        r_stk_ovf <= 1'b0;
        r_stk_unf <= 1'b0;
      end else begin
        if (w_push)    r_sp      <= r_sp + 1'b1;
        if (w_pop)     r_sp      <= r_sp - 1'b1;
        if (w_ovf_set) r_stk_ovf <= 1'b1;
        if (w_unf_set) r_stk_unf <= 1'b1;
      end
    end
  end

  // NOTE: stack storage has no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (w_run_accept && w_push) r_stack[w_push_idx] <= pc_in + 1'b1;
  end

  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign reg_sel   = r_reg_sel;
  assign jmp       = r_jmp;
  assign jmp_addr  = r_jmp_addr;
  assign load      = r_load;
  assign store     = r_store;
  assign rst_f     = r_rst_f;
  assign sp        = r_sp;
  assign stk_ovf   = r_stk_ovf;
  assign stk_unf   = r_stk_unf;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues hand-computed beats,
// an independent monitor pops and compares each beat the DUT hands downstream.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [4:0] OPC_LD = 5'h0A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] data_in = '0;
  logic [7:0]  pc_in = '0;
  logic        zero_f = 1'b0, ls_z_f = 1'b0, gr_z_f = 1'b0;
  logic        in_ready, out_valid, jmp, load, store, rst_f, stk_ovf, stk_unf;
  logic [4:0]  opcode;
  logic [2:0]  reg_sel;
  logic [7:0]  jmp_addr;
  logic [3:0]  sp;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .pc_in(pc_in), .zero_f(zero_f), .ls_z_f(ls_z_f),
    .gr_z_f(gr_z_f), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .reg_sel(reg_sel), .jmp(jmp), .jmp_addr(jmp_addr),
    .load(load), .store(store), .rst_f(rst_f), .sp(sp),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] opc;
    logic [2:0] rs;
    logic       j;
    logic [7:0] addr;
    logic       ld;
    logic       st;
    logic       rf;
    logic [3:0] sptr;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_beat = 0;

  function automatic exp_t mk(input logic [4:0] opc, input logic [2:0] rs,
                              input logic j, input logic [7:0] addr,
                              input logic ld, input logic st, input logic rf,
                              input logic [3:0] sptr, input logic ovf, input logic unf);
    exp_t e;
    e = '{opc: opc, rs: rs, j: j, addr: addr, ld: ld, st: st, rf: rf,
          sptr: sptr, ovf: ovf, unf: unf};
    return e;
  endfunction

  function automatic exp_t dut_beat();
    exp_t a;
    a = {opcode, reg_sel, jmp, jmp_addr, load, store, rst_f, sp, stk_ovf, stk_unf};
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one word; optionally queue the beat it must produce.
  task automatic send(input logic [4:0] opc, input logic [16:0] data, input logic [7:0] pc,
                      input logic [2:0] zlg, input bit expect_out, input exp_t ex);
    bit ok;
    ok = 1'b0;
    data_in  = {opc, 2'b00, data};
    pc_in    = pc;
    {zero_f, ls_z_f, gr_z_f} = zlg;
    in_valid = 1'b1;
    for (int b = 0; b < 20 && !ok; b++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept", 64'(ok), 64'd1);
    if (ok && expect_out) q.push_back(ex);
  endtask

  task automatic put(input logic [4:0] opc, input logic [16:0] data, input logic [7:0] pc,
                     input logic [2:0] zlg, input exp_t ex);
    send(opc, data, pc, zlg, 1'b1, ex);
  endtask

  task automatic drop(input logic [4:0] opc, input logic [16:0] data, input logic [7:0] pc);
    send(opc, data, pc, 3'b000, 1'b0, '0);
  endtask

  // Monitor: every handed-off beat must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        n_beat++;
        if (q.size() == 0) begin
          check($sformatf("unexpected_beat%0d", n_beat), 64'(dut_beat()), 64'h0);
          if (dut_beat() == '0) begin
            n_fail++;
            $display("FAIL unexpected_beat%0d: got a beat, required none", n_beat);
          end
        end else begin
          check($sformatf("beat%0d", n_beat), 64'(dut_beat()), 64'(q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  exp_t rst_vals;

  initial begin
    rst_vals = mk(5'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

    // 1: reset held with in_valid high
    data_in  = {OPC_LD, 2'b00, 17'h08007};
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(dut_beat()), 64'(rst_vals));
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // 2: store
    put(OPC_ST, 17'h14000, 8'h10, 3'b000, mk(OPC_ST, 3'd5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0));

    // 3: CAL/RET with a squashed CAL in the shadow (must not push)
    put(OPC_CAL, 17'h00040, 8'h12, 3'b000, mk(OPC_CAL, 3'd0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0));
    drop(OPC_CAL, 17'h00077, 8'h13);
    put(OPC_RET, 17'h00000, 8'h40, 3'b000, mk(OPC_RET, 3'd0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    drop(OPC_NOP, 17'h00000, 8'h41);

    // 4: conditional branches, flags are {zero, ls_z, gr_z}
    put(OPC_JEZ, 17'h00020, 8'h14, 3'b000, mk(OPC_JEZ, 3'd0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    put(OPC_JEZ, 17'h00020, 8'h15, 3'b100, mk(OPC_JEZ, 3'd0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    drop(OPC_ST, 17'h14000, 8'h16);
    put(OPC_LD, 17'h08007, 8'h20, 3'b000, mk(OPC_LD, 3'd2, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    put(OPC_JNZ, 17'h00021, 8'h21, 3'b010, mk(OPC_JNZ, 3'd0, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    drop(OPC_NOP, 17'h00000, 8'h22);
    put(OPC_JLZ, 17'h00022, 8'h22, 3'b010, mk(OPC_JLZ, 3'd0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    drop(OPC_NOP, 17'h00000, 8'h23);
    put(OPC_JGZ, 17'h00023, 8'h23, 3'b010, mk(OPC_JGZ, 3'd0, 1'b0, 8'h23, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    put(OPC_JNZ, 17'h00024, 8'h24, 3'b100, mk(OPC_JNZ, 3'd0, 1'b0, 8'h24, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    put(OPC_JGZ, 17'h00025, 8'h25, 3'b001, mk(OPC_JGZ, 3'd0, 1'b1, 8'h25, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    drop(OPC_NOP, 17'h00000, 8'h26);

    // 5: stack overflow on the 9th CAL, then RST clears everything
    for (int i = 0; i < 9; i++) begin
      put(OPC_CAL, 17'(8'h50 + i), 8'(8'h30 + i), 3'b000,
          mk(OPC_CAL, 3'd0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1,
             (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0));
      drop(OPC_NOP, 17'h00000, 8'(8'h31 + i));
    end
    put(OPC_RST, 17'h00000, 8'h60, 3'b000, mk(OPC_RST, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    put(OPC_LD, 17'h08007, 8'h61, 3'b000, mk(OPC_LD, 3'd2, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));

    // Return address wraps at the top of the pc range
    put(OPC_CAL, 17'h00030, 8'hFF, 3'b000, mk(OPC_CAL, 3'd0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0));
    drop(OPC_NOP, 17'h00000, 8'h00);
    put(OPC_RET, 17'h00000, 8'h30, 3'b000, mk(OPC_RET, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    drop(OPC_NOP, 17'h00000, 8'h31);

    // Underflowing RET acts as NOP: no squash, sticky flag until RST
    put(OPC_RET, 17'h00000, 8'h01, 3'b000, mk(OPC_RET, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1));
    put(OPC_LD, 17'h08007, 8'h02, 3'b000, mk(OPC_LD, 3'd2, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1));
    put(OPC_RST, 17'h00000, 8'h03, 3'b000, mk(OPC_RST, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));

    // 6: downstream stall for 4 cycles with more words waiting
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    put(OPC_ST, 17'h04000, 8'h04, 3'b000, mk(OPC_ST, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0));
    fork
      begin
        put(OPC_LD, 17'h08007, 8'h05, 3'b000, mk(OPC_LD, 3'd2, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
        put(OPC_NOP, 17'h00005, 8'h06, 3'b000, mk(OPC_NOP, 3'd0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
      end
    join_none
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_hold", c), 64'(dut_beat()),
            64'(mk(OPC_ST, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0)));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;

    // 7: async reset in the middle of a branch shadow
    put(OPC_JMP, 17'h00044, 8'h70, 3'b000, mk(OPC_JMP, 3'd0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midsquash_reset_valid", 64'(out_valid), 64'd0);
    check("midsquash_reset_outputs", 64'(dut_beat()), 64'(rst_vals));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    put(OPC_LD, 17'h08007, 8'h00, 3'b000, mk(OPC_LD, 3'd2, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));

    // Drain and confirm nothing was lost
    for (int d = 0; d < 50 && q.size() != 0; d++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
